// File: rtl/input_fifo_ext_if.sv
// Producer/consumer bus for input_fifo_ext.
// Optional drop_count signal is present only when IBUF_DROP_CNT_EN is defined.
interface input_fifo_ext_if #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic                  flush;
  logic                  clear_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic                  underflow;
`ifdef IBUF_DROP_CNT_EN
  logic [15:0]           drop_count;
`endif

  modport master (
    output push, data_in, pop, flush, clear_err,
    input  data_out, valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
`ifdef IBUF_DROP_CNT_EN
    , input drop_count
`endif
  );

  modport slave (
    input  push, data_in, pop, flush, clear_err,
    output data_out, valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
`ifdef IBUF_DROP_CNT_EN
    , output drop_count
`endif
  );
endinterface

// File: rtl/input_fifo_ext.sv
// Parametrised symbol input FIFO with FWFT option, watermarks, flush and sticky errors.
// Define IBUF_DROP_CNT_EN to add the saturating drop_count output.
module input_fifo_ext #(
  parameter int DEPTH         = 256,
  parameter int DATA_WIDTH    = 8,
  parameter int AFULL_THRESH  = 252,
  parameter int AEMPTY_THRESH = 4,
  parameter int FWFT          = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input_fifo_ext_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level_q;
  logic                  full;
  logic                  empty;
  logic                  pop_ok;
  logic                  push_ok;
  logic                  do_pop;
  logic                  do_push;
  logic                  ovf_ev;
  logic                  unf_ev;
  logic                  overflow_q;
  logic                  underflow_q;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign pop_ok  = bus.pop && !empty;
  // On a full FIFO a push is accepted only into the slot freed by a same-cycle pop.
  assign push_ok = bus.push && (!full || pop_ok);
  assign do_pop  = pop_ok && !bus.flush;
  assign do_push = push_ok && !bus.flush;
  assign ovf_ev  = bus.push && !push_ok && !bus.flush;
  assign unf_ev  = bus.pop && empty && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LW'(1);
      else if (do_pop && !do_push) level_q <= level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= bus.data_in;
  end

  // A new error event wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= ovf_ev | (overflow_q  & ~bus.clear_err);
      underflow_q <= unf_ev | (underflow_q & ~bus.clear_err);
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= do_pop;
          if (do_pop) dout_q <= mem[rd_ptr];
        end
      end

      assign bus.data_out = dout_q;
      assign bus.valid    = valid_q;
    end else begin : g_fwft
      assign bus.data_out = empty ? '0 : mem[rd_ptr];
      assign bus.valid    = !empty;
    end
  endgenerate

`ifdef IBUF_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (bus.clear_err) begin
      drop_cnt_q <= ovf_ev ? 16'd1 : 16'd0;
    end else if (ovf_ev && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.drop_count = drop_cnt_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (level_q >= LW'(AFULL_THRESH));
  assign bus.almost_empty = (level_q <= LW'(AEMPTY_THRESH));
  assign bus.level        = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_input_fifo_ext.sv
// Self-checking bench: registered-read and FWFT instances driven in lockstep
// against a queue-based reference model.
module tb_input_fifo_ext;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  input_fifo_ext_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) b0 ();
  input_fifo_ext_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) b1 ();

  input_fifo_ext #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AFULL_THRESH(AF),
                   .AEMPTY_THRESH(AE), .FWFT(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));

  input_fifo_ext #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AFULL_THRESH(AF),
                   .AEMPTY_THRESH(AE), .FWFT(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  int checks = 0;
  int errors = 0;

  // reference model
  logic [7:0]  q[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  logic [7:0]  m_dout0 = 8'h00;
  logic        m_valid0 = 1'b0;
  logic [15:0] m_dc = 16'd0;

  function automatic logic [17:0] exp_vec(input bit fwft);
    logic [2:0] lv;
    logic       v;
    logic [7:0] d;
    lv = 3'(q.size());
    if (fwft) begin
      v = (q.size() > 0);
      d = (q.size() > 0) ? q[0] : 8'h00;
    end else begin
      v = m_valid0;
      d = m_dout0;
    end
    return {lv, q.size() == DEPTH, q.size() == 0, q.size() >= AF, q.size() <= AE,
            m_ovf, m_unf, v, d};
  endfunction

  function automatic logic [17:0] obs0();
    return {b0.level, b0.full, b0.empty, b0.almost_full, b0.almost_empty,
            b0.overflow, b0.underflow, b0.valid, b0.data_out};
  endfunction

  function automatic logic [17:0] obs1();
    return {b1.level, b1.full, b1.empty, b1.almost_full, b1.almost_empty,
            b1.overflow, b1.underflow, b1.valid, b1.data_out};
  endfunction

  task automatic step(input logic p, input logic [7:0] d, input logic o,
                      input logic f, input logic c);
    logic pok, wok, oev, uev;
    b0.push = p; b0.data_in = d; b0.pop = o; b0.flush = f; b0.clear_err = c;
    b1.push = p; b1.data_in = d; b1.pop = o; b1.flush = f; b1.clear_err = c;
    @(posedge clk);
    pok = o && (q.size() > 0);
    wok = p && ((q.size() < DEPTH) || pok);
    oev = p && !wok && !f;
    uev = o && (q.size() == 0) && !f;
    if (f) begin
      q.delete();
      m_valid0 = 1'b0;
    end else begin
      if (pok) begin
        m_dout0  = q.pop_front();
        m_valid0 = 1'b1;
      end else begin
        m_valid0 = 1'b0;
      end
      if (wok) q.push_back(d);
    end
    m_ovf = oev | (m_ovf & ~c);
    m_unf = uev | (m_unf & ~c);
    if (c) m_dc = oev ? 16'd1 : 16'd0;
    else if (oev && m_dc != 16'hFFFF) m_dc = m_dc + 16'd1;
    #1;
  endtask

  task automatic cleanup();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs0() !== 18'b000_0101_0000_0000000 || obs1() !== 18'b000_0101_0000_0000000) begin
      errors++;
      $display("FAIL reset_state got0=%h got1=%h exp=%h", obs0(), obs1(), 18'b000_0101_0000_0000000);
    end
`ifdef IBUF_DROP_CNT_EN
    checks++;
    if (b0.drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_drop_count got=%0d exp=0", b0.drop_count);
    end
`endif
    #10 rst_n = 1'b1;
    #10;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h41 + i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (b0.full !== 1'b1 || b0.level !== 3'd4 || b0.almost_full !== 1'b1) begin
      errors++;
      $display("FAIL fill_full full=%b level=%0d afull=%b exp 1/4/1", b0.full, b0.level, b0.almost_full);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (b0.valid !== 1'b1 || b0.data_out !== 8'(8'h41 + i)) begin
        errors++;
        $display("FAIL drain_data i=%0d valid=%b data=%h exp 1/%h", i, b0.valid, b0.data_out, 8'(8'h41 + i));
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (b0.empty !== 1'b1 || b0.valid !== 1'b0 || b0.data_out !== 8'h44) begin
      errors++;
      $display("FAIL drain_empty empty=%b valid=%b data=%h exp 1/0/44", b0.empty, b0.valid, b0.data_out);
    end
  endtask

  task automatic test_fwft();
    checks++;
    if (b1.valid !== 1'b0 || b1.data_out !== 8'h00) begin
      errors++;
      $display("FAIL fwft_idle valid=%b data=%h exp 0/00", b1.valid, b1.data_out);
    end
    step(1'b1, 8'h2E, 1'b0, 1'b0, 1'b0);
    checks++;
    if (b1.valid !== 1'b1 || b1.data_out !== 8'h2E) begin
      errors++;
      $display("FAIL fwft_fallthrough valid=%b data=%h exp 1/2e", b1.valid, b1.data_out);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (b1.valid !== 1'b0 || b1.data_out !== 8'h00) begin
      errors++;
      $display("FAIL fwft_after_pop valid=%b data=%h exp 0/00", b1.valid, b1.data_out);
    end
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    checks++;
    if (b0.level !== 3'd4 || b0.overflow !== 1'b0 || b0.data_out !== 8'hA0) begin
      errors++;
      $display("FAIL full_pushpop level=%0d ovf=%b data=%h exp 4/0/a0", b0.level, b0.overflow, b0.data_out);
    end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      e = (i == 3) ? 8'h55 : 8'(8'hA1 + i);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (b0.data_out !== e) begin
        errors++;
        $display("FAIL full_pushpop_order i=%0d got=%h exp=%h", i, b0.data_out, e);
      end
    end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    checks++;
    if (b0.overflow !== 1'b1 || b0.level !== 3'd4) begin
      errors++;
      $display("FAIL overflow_set ovf=%b level=%0d exp 1/4", b0.overflow, b0.level);
    end
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
`ifdef IBUF_DROP_CNT_EN
    checks++;
    if (b0.drop_count !== 16'd3) begin
      errors++;
      $display("FAIL drop_count_3 got=%0d exp=3", b0.drop_count);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (b0.data_out !== 8'(8'h30 + i)) begin
        errors++;
        $display("FAIL overflow_drop i=%0d got=%h exp=%h", i, b0.data_out, 8'(8'h30 + i));
      end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (b0.underflow !== 1'b1 || b0.valid !== 1'b0) begin
      errors++;
      $display("FAIL underflow_set unf=%b valid=%b exp 1/0", b0.underflow, b0.valid);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (b0.overflow !== 1'b0 || b0.underflow !== 1'b0) begin
      errors++;
      $display("FAIL clear_err ovf=%b unf=%b exp 0/0", b0.overflow, b0.underflow);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h98, 1'b0, 1'b0, 1'b1);
    checks++;
    if (b0.overflow !== 1'b1) begin
      errors++;
      $display("FAIL clear_vs_overflow ovf=%b exp 1", b0.overflow);
    end
`ifdef IBUF_DROP_CNT_EN
    checks++;
    if (b0.drop_count !== 16'd1) begin
      errors++;
      $display("FAIL drop_count_clear_inc got=%0d exp=1", b0.drop_count);
    end
`endif
    cleanup();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h21 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    checks++;
    if (b0.level !== 3'd0 || b0.empty !== 1'b1 || b0.valid !== 1'b0 || b1.valid !== 1'b0 ||
        b0.data_out !== 8'h21 || b1.data_out !== 8'h00 ||
        b0.overflow !== 1'b0 || b0.underflow !== 1'b0) begin
      errors++;
      $display("FAIL flush level=%0d empty=%b v0=%b v1=%b d0=%h d1=%h ovf=%b unf=%b exp 0/1/0/0/21/00/0/0",
               b0.level, b0.empty, b0.valid, b1.valid, b0.data_out, b1.data_out, b0.overflow, b0.underflow);
    end
    step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (b0.valid !== 1'b1 || b0.data_out !== 8'h10 || b0.empty !== 1'b1) begin
      errors++;
      $display("FAIL flush_reuse valid=%b data=%h empty=%b exp 1/10/1", b0.valid, b0.data_out, b0.empty);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'h81 + i), 1'b1, 1'b0, 1'b0);
      checks++;
      if (b0.data_out !== 8'(8'h80 + i) || b1.data_out !== 8'(8'h81 + i) || b0.level !== 3'd1) begin
        errors++;
        $display("FAIL wrap i=%0d d0=%h d1=%h level=%0d exp %h/%h/1",
                 i, b0.data_out, b1.data_out, b0.level, 8'(8'h80 + i), 8'(8'h81 + i));
      end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic p, o, f, c;
      p = ($urandom_range(99) < 55);
      o = ($urandom_range(99) < 50);
      f = ($urandom_range(99) < 4);
      c = !f && ($urandom_range(99) < 5);
      step(p, 8'($urandom), o, f, c);
      checks++;
      if (obs0() !== exp_vec(1'b0)) begin
        errors++;
        $display("FAIL rnd_regread n=%0d got=%h exp=%h", n, obs0(), exp_vec(1'b0));
      end
      checks++;
      if (obs1() !== exp_vec(1'b1)) begin
        errors++;
        $display("FAIL rnd_fwft n=%0d got=%h exp=%h", n, obs1(), exp_vec(1'b1));
      end
`ifdef IBUF_DROP_CNT_EN
      checks++;
      if (b0.drop_count !== m_dc) begin
        errors++;
        $display("FAIL rnd_drop_count n=%0d got=%0d exp=%0d", n, b0.drop_count, m_dc);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    cleanup();
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_dout0 = 8'h00; m_valid0 = 1'b0; m_dc = 16'd0;
    #1;
    checks++;
    if (obs0() !== exp_vec(1'b0) || obs1() !== exp_vec(1'b1)) begin
      errors++;
      $display("FAIL reset_mid got0=%h got1=%h exp0=%h exp1=%h", obs0(), obs1(), exp_vec(1'b0), exp_vec(1'b1));
    end
`ifdef IBUF_DROP_CNT_EN
    checks++;
    if (b0.drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_drop_count got=%0d exp=0", b0.drop_count);
    end
`endif
    #2 rst_n = 1'b1;
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (b0.data_out !== 8'h5A || b0.valid !== 1'b1 || b0.empty !== 1'b1) begin
      errors++;
      $display("FAIL post_reset data=%h valid=%b empty=%b exp 5a/1/1", b0.data_out, b0.valid, b0.empty);
    end
  endtask

  initial begin
    b0.push = 1'b0; b0.data_in = '0; b0.pop = 1'b0; b0.flush = 1'b0; b0.clear_err = 1'b0;
    b1.push = 1'b0; b1.data_in = '0; b1.pop = 1'b0; b1.flush = 1'b0; b1.clear_err = 1'b0;
    test_reset();
    test_fill_drain();
    test_fwft();
    test_full_pushpop();
    test_errors();
    test_flush();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout waited=500000 limit=500000");
    $fatal(1);
  end
endmodule
